biquad8_pole_coeff_loader: RTL
==============================

BIQUAD8_POLE_COEFF_LOADER -- requirements
Module: biquad8_pole_coeff_loader

Interface
REQ-001 Parameter: COEFF_BITS, default 18, width of each coefficient word.
REQ-002 Parameter: NCOEFF, default 4, number of coefficients per pole-IIR load: A, B, C, D at addresses 0..3.
REQ-003 Port: clk, input, 1, single clock for all logic.
REQ-004 Port: rst, input, 1, synchronous active-high reset.
REQ-005 Port: host_adr_i, input, 2, shadow-register address for host write or readback.
REQ-006 Port: host_dat_i, input, COEFF_BITS, host write data.
REQ-007 Port: host_wr_i, input, 1, one-cycle write strobe into the shadow register.
REQ-008 Port: load_i, input, 1, one-cycle request to commit the shadow set to the IIR.
REQ-009 Port: busy_o, output, 1, high while a load sequence is in progress.
REQ-010 Port: done_o, output, 1, one-cycle pulse when a load completes.
REQ-011 Port: coeff_dat_o, output, COEFF_BITS, serial coefficient to the IIR B-cascade input.
REQ-012 Port: coeff_wr_o, output, 1, shift-enable to the IIR first-stage B registers.
REQ-013 Port: coeff_update_o, output, 1, one-cycle pulse that transfers shifted coefficients to the IIR active registers.

Function
REQ-014 Four shadow registers SHALL be written on host_wr_i at host_adr_i in any state; the write takes effect the next cycle.
REQ-015 On load_i in IDLE at cycle N, all four shadow values SHALL be copied to a snapshot at edge N+1; later host writes SHALL NOT affect that load.
REQ-016 FSM states SHALL be IDLE, SHIFT, UPDATE: IDLE->SHIFT on load_i; SHIFT->UPDATE after NCOEFF shift cycles; UPDATE->IDLE after one cycle.
REQ-017 In SHIFT, coeff_wr_o SHALL be high for cycles N+1..N+4, with coeff_dat_o = D, C, B, A in that order, so that A lands in the first DSP.
REQ-018 coeff_update_o SHALL pulse high at cycle N+5, and done_o SHALL pulse in the same cycle.
REQ-019 busy_o SHALL be high for cycles N+1..N+5 and low otherwise.
REQ-020 A load_i arriving while busy_o is high SHALL set a pending flag; multiple such requests collapse to one.
REQ-021 If the pending flag is set in UPDATE, the FSM SHALL go directly to SHIFT with a fresh snapshot, and the flag SHALL be cleared.
REQ-022 A load_i in the same cycle as a host_wr_i SHALL snapshot the pre-write shadow value.
REQ-023 coeff_wr_o and coeff_update_o SHALL never be high in the same cycle.
REQ-024 When coeff_wr_o is low, coeff_dat_o SHALL be 0.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 rst SHALL force IDLE, clear the pending flag, zero all shadow and snapshot registers, and drive busy_o, done_o, coeff_wr_o, coeff_update_o = 0 and coeff_dat_o = 0.
REQ-027 A reset asserted mid-SHIFT SHALL abort the sequence with no coeff_update_o pulse; the IIR active coefficients SHALL remain unchanged.

Configuration
REQ-028 With BIQUAD8_COEFF_READBACK_EN defined, the block SHALL add output host_rdat_o [COEFF_BITS], a registered copy of shadow[host_adr_i] with one-cycle latency and reset value 0.
REQ-029 Without BIQUAD8_COEFF_READBACK_EN, host_rdat_o SHALL be absent and no readback multiplexer SHALL be built.

Structure
REQ-030 The FSM state encodings, the COEFF_BITS default and the address constants ADR_A=0, ADR_B=1, ADR_C=2, ADR_D=3 SHALL reside in the shared package biquad8_pkg.
REQ-031 The shadow register file plus snapshot SHALL be one sub-module, biquad8_coeff_shadow; the FSM and output registers SHALL stay in the top level.

Verification
REQ-032 Scenario: write A=0x00001, B=0x00002, C=0x3FFFF, D=0x20000, then load_i -> coeff_wr_o high for 4 cycles with 0x20000, 0x3FFFF, 0x00002, 0x00001, then coeff_update_o and done_o for 1 cycle; busy_o high for 5 cycles.
REQ-033 Scenario: write A=0x00005 two cycles after load_i -> the shifted value of A is the old one; a second load_i then shifts 0x00005.
REQ-034 Scenario: three load_i pulses during busy -> exactly one extra sequence back-to-back, with update pulses 5 cycles apart and no IDLE cycle between them.
REQ-035 Scenario: rst at the 2nd SHIFT cycle -> no coeff_update_o pulse, all outputs 0 the next cycle, shadow reads 0 (readback build).
REQ-036 Scenario: load_i and host_wr_i to address 0 with value 0x00AAA in the same cycle -> the last shifted word is the old A; readback of address 0 is 0x00AAA.
REQ-037 Scenario: bench model of the four-DSP B chain (shift on coeff_wr_o, latch on coeff_update_o) -> active registers equal A, B, C, D in DSP0..DSP3 after every load.

Source files
------------

// File: rtl/biquad8_pkg.sv
// Shared constants and FSM encoding for the biquad8 pole-coefficient loader.
package biquad8_pkg;

  localparam int unsigned COEFF_BITS_DEFAULT = 18;

  localparam logic [1:0] ADR_A = 2'd0;
  localparam logic [1:0] ADR_B = 2'd1;
  localparam logic [1:0] ADR_C = 2'd2;
  localparam logic [1:0] ADR_D = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StUpdate = 2'd2
  } state_e;

endpackage

// File: rtl/biquad8_coeff_shadow.sv
// Host-writable shadow coefficient file plus the snapshot frozen at the start of each load.
// With BIQUAD8_COEFF_READBACK_EN defined, also exposes a combinational shadow read port.
module biquad8_coeff_shadow
  import biquad8_pkg::*;
#(
  parameter int unsigned COEFF_BITS = COEFF_BITS_DEFAULT,
  parameter int unsigned NCOEFF     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr,
  input  logic [1:0]            i_adr,
  input  logic [COEFF_BITS-1:0] i_dat,
  input  logic                  i_snap,
  input  logic [1:0]            i_sel,
  output logic [COEFF_BITS-1:0] o_snap_dat,
  output logic [COEFF_BITS-1:0] o_shadow_last
`ifdef BIQUAD8_COEFF_READBACK_EN
  ,
  output logic [COEFF_BITS-1:0] o_rd_dat
`endif
);

  localparam logic [1:0] LastIdx = 2'(NCOEFF - 1);

  logic [COEFF_BITS-1:0] r_shadow [NCOEFF];
  logic [COEFF_BITS-1:0] r_snap   [NCOEFF];

  // Snapshot reads the pre-write shadow, so a same-cycle host write misses this load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCOEFF; i++) begin
        r_shadow[i] <= '0;
        r_snap[i]   <= '0;
      end
    end else begin
      if (i_snap) begin
        for (int unsigned i = 0; i < NCOEFF; i++) begin
          r_snap[i] <= r_shadow[i];
        end
      end
      if (i_wr) begin
        r_shadow[i_adr] <= i_dat;
      end
    end
  end

  assign o_snap_dat    = r_snap[i_sel];
  assign o_shadow_last = r_shadow[LastIdx];

`ifdef BIQUAD8_COEFF_READBACK_EN
  assign o_rd_dat = r_shadow[i_adr];
`endif

endmodule

// File: rtl/biquad8_pole_coeff_loader.sv
// Commits the shadow coefficient set to the IIR B-cascade: shifts D,C,B,A then pulses update.
// Optional registered readback port built when BIQUAD8_COEFF_READBACK_EN is defined.
module biquad8_pole_coeff_loader
  import biquad8_pkg::*;
#(
  parameter int unsigned COEFF_BITS = COEFF_BITS_DEFAULT,
  parameter int unsigned NCOEFF     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            host_adr_i,
  input  logic [COEFF_BITS-1:0] host_dat_i,
  input  logic                  host_wr_i,
  input  logic                  load_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [COEFF_BITS-1:0] coeff_dat_o,
  output logic                  coeff_wr_o,
  output logic                  coeff_update_o
`ifdef BIQUAD8_COEFF_READBACK_EN
  ,
  output logic [COEFF_BITS-1:0] host_rdat_o
`endif
);

  localparam logic [1:0] LastIdx = 2'(NCOEFF - 1);

  state_e                r_state;
  logic                  r_pending;
  logic [1:0]            r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_wr;
  logic                  r_upd;
  logic [COEFF_BITS-1:0] r_dat;

  logic                  w_start;
  logic [1:0]            w_sel;
  logic [COEFF_BITS-1:0] w_snap_dat;
  logic [COEFF_BITS-1:0] w_shadow_last;

  assign w_start = ((r_state == StIdle) && load_i) ||
                   ((r_state == StUpdate) && (r_pending || load_i));
  // r_cnt words already sent; next word walks down from the one below the last.
  assign w_sel   = LastIdx - 2'd1 - r_cnt;

`ifdef BIQUAD8_COEFF_READBACK_EN
  logic [COEFF_BITS-1:0] w_rd_dat;
  logic [COEFF_BITS-1:0] r_rdat;
`endif

  biquad8_coeff_shadow #(
    .COEFF_BITS (COEFF_BITS),
    .NCOEFF     (NCOEFF)
  ) u_shadow (
    .clk           (clk),
    .rst           (rst),
    .i_wr          (host_wr_i),
    .i_adr         (host_adr_i),
    .i_dat         (host_dat_i),
    .i_snap        (w_start),
    .i_sel         (w_sel),
    .o_snap_dat    (w_snap_dat),
    .o_shadow_last (w_shadow_last)
`ifdef BIQUAD8_COEFF_READBACK_EN
    ,
    .o_rd_dat      (w_rd_dat)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_pending <= 1'b0;
      r_cnt     <= 2'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr      <= 1'b0;
      r_upd     <= 1'b0;
      r_dat     <= '0;
    end else begin
      r_done <= 1'b0;
      r_upd  <= 1'b0;
      r_wr   <= 1'b0;
      r_dat  <= '0;
      if (load_i && (r_state != StIdle)) begin
        r_pending <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (load_i) begin
            r_state <= StShift;
            r_busy  <= 1'b1;
            r_cnt   <= 2'd0;
            r_wr    <= 1'b1;
            // First word comes straight from the shadow; the snapshot lands this same edge.
            r_dat   <= w_shadow_last;
          end
        end
        StShift: begin
          if (r_cnt == LastIdx) begin
            r_state <= StUpdate;
            r_upd   <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 2'd1;
            r_wr  <= 1'b1;
            r_dat <= w_snap_dat;
          end
        end
        StUpdate: begin
          if (r_pending || load_i) begin
            r_state   <= StShift;
            r_pending <= 1'b0;
            r_cnt     <= 2'd0;
            r_wr      <= 1'b1;
            r_dat     <= w_shadow_last;
          end else begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign coeff_wr_o     = r_wr;
  assign coeff_update_o = r_upd;
  assign coeff_dat_o    = r_dat;

`ifdef BIQUAD8_COEFF_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdat <= '0;
    end else begin
      r_rdat <= w_rd_dat;
    end
  end

  assign host_rdat_o = r_rdat;
`endif

endmodule
